// File: rtl/seven_segment_control_pkg.sv
// Shared seven-segment constants: blank pattern and the active-low hex glyph table.
// Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seven_segment_control_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_segment_control_hex_to_seg.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
// Every code maps to a glyph, so no blanking fallback is needed.
module hex_to_seg
  import seven_segment_control_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_segment_control.sv
// Registered driver for eight active-low 7-segment displays with per-digit enables.
// Each digit decodes its nibble, masks it with its enable bit and registers the result.
module seven_segment_control
  import seven_segment_control_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in7,
  input  logic [3:0] in6,
  input  logic [3:0] in5,
  input  logic [3:0] in4,
  input  logic [3:0] in3,
  input  logic [3:0] in2,
  input  logic [3:0] in1,
  input  logic [3:0] in0,
  input  logic [7:0] turn_on,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  logic [3:0] nib   [8];
  logic [6:0] seg   [8];
  logic [6:0] hex_d [8];
  logic [6:0] hex_q [8];

  assign nib[0] = in0;
  assign nib[1] = in1;
  assign nib[2] = in2;
  assign nib[3] = in3;
  assign nib[4] = in4;
  assign nib[5] = in5;
  assign nib[6] = in6;
  assign nib[7] = in7;

  for (genvar i = 0; i < 8; i++) begin : g_dec
    hex_to_seg u_dec (
      .hex (nib[i]),
      .seg (seg[i])
    );
  end

  // Disabled digits are forced dark; enabled digits show their decoded glyph.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (turn_on[i]) begin
        hex_d[i] = seg[i];
      end else begin
        hex_d[i] = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_seven_segment_control.sv
// Self-checking bench for seven_segment_control: directed plan steps plus random traffic,
// checked against a model that builds glyphs from lists of lit segment letters.
module tb_seven_segment_control;

  logic       clock;
  logic       reset;
  logic [3:0] nib [8];
  logic [7:0] turn_on;
  logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [6:0] hex [8];

  int total = 0;
  int bad   = 0;

  seven_segment_control dut (
    .clock   (clock),
    .reset   (reset),
    .in7     (nib[7]),
    .in6     (nib[6]),
    .in5     (nib[5]),
    .in4     (nib[4]),
    .in3     (nib[3]),
    .in2     (nib[2]),
    .in1     (nib[1]),
    .in0     (nib[0]),
    .turn_on (turn_on),
    .HEX7    (HEX7),
    .HEX6    (HEX6),
    .HEX5    (HEX5),
    .HEX4    (HEX4),
    .HEX3    (HEX3),
    .HEX2    (HEX2),
    .HEX1    (HEX1),
    .HEX0    (HEX0)
  );

  assign hex[0] = HEX0;
  assign hex[1] = HEX1;
  assign hex[2] = HEX2;
  assign hex[3] = HEX3;
  assign hex[4] = HEX4;
  assign hex[5] = HEX5;
  assign hex[6] = HEX6;
  assign hex[7] = HEX7;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Which segments light up for each hex glyph, written as the letters a..g.
  function automatic string lit_segments(input logic [3:0] v);
    case (v)
      4'h0: return "abcdef";
      4'h1: return "bc";
      4'h2: return "abdeg";
      4'h3: return "abcdg";
      4'h4: return "bcfg";
      4'h5: return "acdfg";
      4'h6: return "acdefg";
      4'h7: return "abc";
      4'h8: return "abcdefg";
      4'h9: return "abcdfg";
      4'hA: return "abcefg";
      4'hB: return "cdefg";
      4'hC: return "adef";
      4'hD: return "bcdeg";
      4'hE: return "adefg";
      default: return "aefg";
    endcase
  endfunction

  // Active-low pattern: start all dark, clear the bit of each lit segment.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] p;
    s = lit_segments(v);
    p = 7'h7F;
    for (int k = 0; k < s.len(); k++) begin
      p[s[k] - "a"] = 1'b0;
    end
    return p;
  endfunction

  function automatic logic [6:0] expect_digit(input int i);
    if (reset) return 7'h7F;
    if (!turn_on[i]) return 7'h7F;
    return glyph(nib[i]);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [6:0] e;
    for (int i = 0; i < 8; i++) begin
      e = expect_digit(i);
      total++;
      assert (hex[i] === e) else begin
        bad++;
        $error("FAIL %s HEX%0d got=%h want=%h", tag, i, hex[i], e);
      end
    end
  endtask

  task automatic check_one(input string tag, input int i, input logic [6:0] e);
    total++;
    assert (hex[i] === e) else begin
      bad++;
      $error("FAIL %s HEX%0d got=%h want=%h", tag, i, hex[i], e);
    end
  endtask

  task automatic set_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) nib[i] = w[4*i +: 4];
  endtask

  logic [6:0] lit_pat [8];

  initial begin
    reset   = 1'b1;
    turn_on = 8'hFF;
    set_word(32'h9F3C_5A17);

    // Reset held two cycles with changing inputs.
    tick();
    check_all("reset1");
    set_word(32'h0123_4567);
    tick();
    check_all("reset2");

    // Full-digit sweep, first post-reset update included.
    reset = 1'b0;
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < 8; i++) nib[i] = v[3:0];
      tick();
      check_all($sformatf("sweep_%0h", v));
    end

    // Top-level pattern against literal glyph values.
    lit_pat = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    set_word(32'h1234_ABCD);
    turn_on = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) check_one("pattern_lit", i, lit_pat[i]);

    turn_on = 8'hA5;
    tick();
    check_all("mask_a5");
    check_one("mask_a5_off6", 6, 7'h7F);
    turn_on = 8'h5A;
    tick();
    check_all("mask_5a");
    check_one("mask_5a_off7", 7, 7'h7F);

    // Single-digit change: only HEX3 moves, and only at the next edge.
    turn_on = 8'hFF;
    set_word(32'h1234_0BCD);
    tick();
    check_one("indep_pre", 3, 7'h40);
    nib[3] = 4'h9;
    #2;
    check_one("indep_nocomb", 3, 7'h40);
    tick();
    check_all("indep_post");
    check_one("indep_hex3", 3, 7'h10);

    // Mid-stream reset and recovery with inputs held.
    reset = 1'b1;
    tick();
    check_all("midreset");
    reset = 1'b0;
    tick();
    check_all("recover");
    check_one("recover_hex7", 7, 7'h79);

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 8; i++) nib[i] = 4'($urandom_range(0, 15));
      turn_on = 8'($urandom);
      reset   = ($urandom_range(0, 9) == 0);
      tick();
      check_all($sformatf("rand_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
